display_p2s_out: RTL
====================

# display_p2s_out

Serial output driver for the board's seven-segment and LED shift-register chains (74HC595-style). It is the output-side counterpart of the switch/button input path. It continuously snapshots eight hex digits, decimal points, blank mask and 16 LED bits, and encodes the digits to segment patterns. It shifts the frames out MSB-first on a divided serial clock, then pulses the latch so the displays update without tearing.

## Interface
- `DIV`, default 2: serial-clock half-period in `clk` cycles; legal range 1..255.
- `GAP`, default 16: idle `clk` cycles between the end of one latch pulse and the next snapshot.
- `clk`, input, 1: system clock.
- `RSTN`, input, 1: asynchronous, active-low reset.
- `hex_data`, input, 32: digit 7 is `[31:28]` … digit 0 is `[3:0]`.
- `point`, input, 8: decimal point per digit, 1 = lit.
- `blank`, input, 8: blank mask per digit, 1 = all segments off, including dp.
- `led_data`, input, 16: LED states, 1 = lit.
- `seg_clk`, `seg_dout`, `seg_pen`, `seg_clrn`, outputs, 1 each: segment chain shift clock, data, latch, clear (active low).
- `led_clk`, `led_dout`, `led_pen`, `led_clrn`, outputs, 1 each: LED chain, same roles.
- `busy`, output, 1: high from snapshot through the end of the latch pulse.
- `frame_done`, output, 1: one-`clk` pulse on the cycle after the last latch pulse of a refresh ends.

## Operation
- All outputs are registered.
- Reset values: every `*_clk`, `*_dout` and `*_pen` = 0; `*_clrn` = 0; `busy` = 0; `frame_done` = 0; FSM = IDLE.
- `*_clrn` rises on the first `clk` edge after `RSTN` deasserts and stays 1 until the next reset.
- **FSM states:** IDLE → LOAD → SEG_SHIFT → SEG_LATCH → LED_SHIFT → LED_LATCH → GAP_WAIT → LOAD …
  - IDLE lasts exactly one cycle after reset.
  - LOAD (1 cycle): captures all inputs into snapshot registers, encodes the segment frame into a 64-bit shift register and the LEDs into a 16-bit shift register, and sets `busy` = 1.
  - Input changes after LOAD never affect the frame in flight.
- **Segment byte per digit:** active low, byte[7]=dp, byte[6:0]={g,f,e,d,c,b,a}.
  - Blanked digit → 8'hFF.
  - Digit 7 goes out first; each byte is sent MSB first.
  - Hex font (active-high a..g before inversion): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- **LED frame:** bit value inverted (LEDs are active-low), `led_data[15]` first.
- **Shifting:** each bit occupies 2·DIV `clk` cycles.
  - `dout` is updated on the cycle `*_clk` goes 0; `*_clk` is held 0 for DIV cycles, then 1 for DIV cycles.
  - The chain samples on the `*_clk` rising edge.
  - A bit counter ends the state after 64 (seg) or 16 (LED) rising edges.
- **Latch:** after the final bit's high phase, `*_clk` returns to 0 and `*_pen` is 1 for DIV cycles, then 0.
- **GAP_WAIT:** `busy` = 0 for GAP cycles. `frame_done` pulses on the first GAP_WAIT cycle.
- **Reset mid-frame:** all outputs return to reset values immediately (asynchronously). The partial frame is discarded; the next refresh restarts at LOAD.
- Idle chain: `clk`/`pen` = 0, `dout` holds its last value.

## Timing
- Latency from LOAD to the first `seg_clk` rise = DIV+1 cycles.
- SEG_SHIFT lasts 128·DIV cycles; SEG_LATCH lasts DIV cycles.
- LED_SHIFT lasts 32·DIV cycles; LED_LATCH lasts DIV cycles.
- Refresh period with LEDs = 1 + 162·DIV + GAP cycles; at defaults this is 341.
- Refresh period without the LED chain = 1 + 129·DIV + GAP cycles.
- `dout` is stable for DIV cycles on both sides of every `*_clk` rise.
- `pen` never overlaps a high `*_clk`.

## Configuration
- `LED_CHAIN_EN` defined: the LED frame is shifted after the segment frame as above.
- `LED_CHAIN_EN` undefined:
  - LED_SHIFT/LED_LATCH are removed.
  - SEG_LATCH → GAP_WAIT directly.
  - `led_clk`/`led_dout`/`led_pen` are tied to 0 and `led_clrn` to 0 (chain held cleared).
  - `led_data` is ignored.

## Test plan
- **Digit frame:** reset, DIV=2, `hex_data`=32'h0123_89AF, `point`=0, `blank`=0 → 64 sampled `seg_dout` bits = C0,F9,A4,B0,80,90,88,8E; `seg_pen` high 2 cycles; `frame_done` pulses once; period 341 cycles.
- **Point/blank:** `hex_data`=32'h0, `point`=8'h01, `blank`=8'h80 → first byte FF, bytes 2–7 C0, last byte 40.
- **LED chain** (`LED_CHAIN_EN`): `led_data`=16'h8001 → sampled `led_dout` = 0,1×14,0; `led_pen` pulses after the `seg_pen` pulse.
- **Snapshot isolation:** change `hex_data` from 32'h1111_1111 to 32'h2222_2222 mid-SEG_SHIFT → current frame is all F9; next frame is all A4.
- **Reset mid-frame:** drop `RSTN` at bit 30 → `seg_clk`/`seg_pen`/`busy` = 0 and `seg_clrn` = 0 asynchronously; after release, `clrn` = 1 next cycle and a full 64-bit frame follows.
- **DIV=1, `LED_CHAIN_EN` undefined:** refresh period = 146 cycles; `led_*` outputs constant 0.

Source files
------------

// File: rtl/display_p2s_out.sv
// Snapshots eight hex digits, points, blank mask and LEDs, encodes 7-segment bytes and shifts them MSB-first
// into 74HC595-style chains with a latch pulse. Define LED_CHAIN_EN to also drive the LED chain.
module display_p2s_out #(
  parameter int DIV = 2,
  parameter int GAP = 16
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic [31:0] hex_data,
  input  logic [7:0]  point,
  input  logic [7:0]  blank,
  input  logic [15:0] led_data,
  output logic        seg_clk,
  output logic        seg_dout,
  output logic        seg_pen,
  output logic        seg_clrn,
  output logic        led_clk,
  output logic        led_dout,
  output logic        led_pen,
  output logic        led_clrn,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEG_SHIFT = 3'd2,
    SEG_LATCH = 3'd3,
    LED_SHIFT = 3'd4,
    LED_LATCH = 3'd5,
    GAP_WAIT  = 3'd6
  } state_t;

  localparam logic [15:0] HALF    = 16'(DIV);
  localparam logic [15:0] HALF_M1 = 16'(DIV - 1);
  localparam logic [15:0] BIT_END = 16'(2 * DIV - 1);
  localparam logic [15:0] GAP_M1  = 16'(GAP - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic [63:0] seg_sr_q, seg_sr_d;
  logic        seg_clk_q, seg_clk_d, seg_dout_q, seg_dout_d, seg_pen_q, seg_pen_d;
  logic        seg_clrn_q, busy_q, busy_d, frame_done_q, frame_done_d;
  logic [63:0] seg_frame;

  // Active-high a..g font; the dp bit is prepended and the byte inverted below.
  function automatic logic [6:0] font(input logic [3:0] h);
    case (h)
      4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
      4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
      4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
      4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
    endcase
  endfunction

  function automatic logic [63:0] encode_frame(input logic [31:0] h, input logic [7:0] p,
                                               input logic [7:0] b);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i*8 +: 8] = b[i] ? 8'hFF : ~{p[i], font(h[i*4 +: 4])};
    end
    return f;
  endfunction

  assign seg_frame = encode_frame(hex_data, point, blank);

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  // cnt_q times the clock phases within a bit, the latch pulse and the gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        state_d = SEG_SHIFT;
        cnt_d   = '0;
        bit_d   = '0;
      end
      SEG_SHIFT: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (bit_q == 6'd63) state_d = SEG_LATCH;
          else                bit_d   = bit_q + 6'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SEG_LATCH: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
`ifdef LED_CHAIN_EN
          state_d = LED_SHIFT;
`else
          state_d = GAP_WAIT;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef LED_CHAIN_EN
      LED_SHIFT: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (bit_q == 6'd15) state_d = LED_LATCH;
          else                bit_d   = bit_q + 6'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LED_LATCH: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = GAP_WAIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      GAP_WAIT: begin
        if (cnt_q == GAP_M1) state_d = LOAD;
        else                 cnt_d   = cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so every pin changes on the same edge as the FSM.
  always_comb begin
    seg_clk_d    = (state_d == SEG_SHIFT) && (cnt_d >= HALF);
    seg_pen_d    = (state_d == SEG_LATCH);
    busy_d       = (state_d != IDLE) && (state_d != GAP_WAIT);
    frame_done_d = (state_d == GAP_WAIT) && (state_q != GAP_WAIT);
    seg_sr_d     = seg_sr_q;
    seg_dout_d   = seg_dout_q;
    if (state_q == LOAD) begin
      seg_dout_d = seg_frame[63];
      seg_sr_d   = {seg_frame[62:0], 1'b0};
    end else if ((state_d == SEG_SHIFT) && (cnt_d == 16'd0)) begin
      seg_dout_d = seg_sr_q[63];
      seg_sr_d   = {seg_sr_q[62:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      seg_sr_q     <= '0;
      seg_clk_q    <= 1'b0;
      seg_dout_q   <= 1'b0;
      seg_pen_q    <= 1'b0;
      seg_clrn_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      seg_sr_q     <= seg_sr_d;
      seg_clk_q    <= seg_clk_d;
      seg_dout_q   <= seg_dout_d;
      seg_pen_q    <= seg_pen_d;
      seg_clrn_q   <= 1'b1;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef LED_CHAIN_EN
  logic [15:0] led_sr_q, led_sr_d;
  logic        led_clk_q, led_clk_d, led_dout_q, led_dout_d, led_pen_q, led_pen_d, led_clrn_q;

  // LEDs are active-low, so the snapshot is stored inverted.
  always_comb begin
    led_clk_d  = (state_d == LED_SHIFT) && (cnt_d >= HALF);
    led_pen_d  = (state_d == LED_LATCH);
    led_sr_d   = led_sr_q;
    led_dout_d = led_dout_q;
    if (state_q == LOAD) begin
      led_sr_d = ~led_data;
    end else if ((state_d == LED_SHIFT) && (cnt_d == 16'd0)) begin
      led_dout_d = led_sr_q[15];
      led_sr_d   = {led_sr_q[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      led_sr_q   <= '0;
      led_clk_q  <= 1'b0;
      led_dout_q <= 1'b0;
      led_pen_q  <= 1'b0;
      led_clrn_q <= 1'b0;
    end else begin
      led_sr_q   <= led_sr_d;
      led_clk_q  <= led_clk_d;
      led_dout_q <= led_dout_d;
      led_pen_q  <= led_pen_d;
      led_clrn_q <= 1'b1;
    end
  end

  assign led_clk  = led_clk_q;
  assign led_dout = led_dout_q;
  assign led_pen  = led_pen_q;
  assign led_clrn = led_clrn_q;
`else
  logic unused_led;
  assign unused_led = ^led_data;
  assign led_clk    = 1'b0;
  assign led_dout   = 1'b0;
  assign led_pen    = 1'b0;
  assign led_clrn   = 1'b0;
`endif

  assign seg_clk    = seg_clk_q;
  assign seg_dout   = seg_dout_q;
  assign seg_pen    = seg_pen_q;
  assign seg_clrn   = seg_clrn_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule
